// File: rtl/logs_popseq_pkg.sv
// Shared types and width helpers for the sequential board-population counter.
package logs_popseq_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row address width: at least one bit, even for a single-row board.
    function automatic int calc_wa(input int nrows);
        return (nrows > 1) ? $clog2(nrows) : 1;
    endfunction

    // Width of one row count (0..ncols).
    function automatic int calc_wr(input int ncols);
        return $clog2(ncols + 1);
    endfunction

    // Width of a full board total (0..nrows*ncols).
    function automatic int calc_wt(input int nrows, input int ncols);
        return $clog2(nrows * ncols + 1);
    endfunction

endpackage

// File: rtl/logs_popcount.sv
// Combinational population count of one NBITS-wide row.
module logs_popcount
    import logs_popseq_pkg::*;
#(
    parameter  int NBITS = 5,
    localparam int WR    = calc_wr(NBITS)
) (
    input  logic [NBITS-1:0] bits,
    output logic [WR-1:0]    count
);

    // Sum the set bits of the row.
    always_comb begin
        count = '0;
        for (int i = 0; i < NBITS; i++) begin
            count = count + WR'(bits[i]);
        end
    end

endmodule

// File: rtl/logs_popcount_seq.sv
// Sequential board-population counter: reads the board row by row over a
// req/ack port, sums each row with one shared popcount and publishes the
// board total with a one-cycle done pulse.
// Optional feature: define LOGS_POPSEQ_ROWMAX_EN to add the row_max output
// (largest single-row count of the last completed scan).
module logs_popcount_seq
    import logs_popseq_pkg::*;
#(
    parameter  int NROWS = 5,
    parameter  int NCOLS = 5,
    localparam int WA    = calc_wa(NROWS),
    localparam int WR    = calc_wr(NCOLS),
    localparam int WT    = calc_wt(NROWS, NCOLS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             rd_req,
    output logic [WA-1:0]    rd_addr,
    input  logic             rd_ack,
    input  logic [NCOLS-1:0] rd_data,
    output logic             done,
    output logic [WT-1:0]    total,
`ifdef LOGS_POPSEQ_ROWMAX_EN
    output logic [WR-1:0]    row_max,
`endif
    output logic             all_clear
);

    localparam logic [WA-1:0] LAST_ROW = WA'(NROWS - 1);

    state_t        state_reg, state_next;
    logic [WA-1:0] row_reg,   row_next;
    logic [WT-1:0] acc_reg,   acc_next;
    logic [WT-1:0] total_reg, total_next;

    logic [WR-1:0] row_cnt;
    logic [WT-1:0] row_sum;

    // The single row counter, shared by every row of the scan.
    logs_popcount #(
        .NBITS (NCOLS)
    ) u_popcount (
        .bits  (rd_data),
        .count (row_cnt)
    );

    assign row_sum = acc_reg + WT'(row_cnt);

`ifdef LOGS_POPSEQ_ROWMAX_EN
    logic [WR-1:0] rmax_run_reg, rmax_run_next;
    logic [WR-1:0] row_max_reg,  row_max_next;
    logic [WR-1:0] rmax_cand;

    assign rmax_cand = (row_cnt > rmax_run_reg) ? row_cnt : rmax_run_reg;

    // Running maximum across the scan, published together with the total.
    always_comb begin
        rmax_run_next = rmax_run_reg;
        row_max_next  = row_max_reg;
        case (state_reg)
            IDLE: if (start) rmax_run_next = '0;
            REQ: begin
                if (rd_ack) begin
                    rmax_run_next = rmax_cand;
                    if (row_reg == LAST_ROW) row_max_next = rmax_cand;
                end
            end
            default: ;
        endcase
    end

    // Row-maximum registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rmax_run_reg <= '0;
            row_max_reg  <= '0;
        end else begin
            rmax_run_reg <= rmax_run_next;
            row_max_reg  <= row_max_next;
        end
    end

    assign row_max = row_max_reg;
`endif

    // Next-state logic: row walk, accumulation, and total latch at DONE entry.
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        acc_next   = acc_reg;
        total_next = total_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    row_next   = '0;
                    acc_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (rd_ack) begin
                    acc_next = row_sum;
                    if (row_reg == LAST_ROW) begin
                        total_next = row_sum;
                        state_next = DONE;
                    end else begin
                        row_next = row_reg + WA'(1);
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State registers; reset abandons any scan in flight and clears the total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            acc_reg   <= '0;
            total_reg <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            acc_reg   <= acc_next;
            total_reg <= total_next;
        end
    end

    // Outputs decode registered state only, so rd_ack/rd_data never reach them.
    assign busy      = (state_reg == REQ);
    assign rd_req    = (state_reg == REQ);
    assign rd_addr   = (state_reg == REQ) ? row_reg : '0;
    assign done      = (state_reg == DONE);
    assign total     = total_reg;
    assign all_clear = (total_reg == '0);

endmodule

// File: doc/logs_popcount_seq.md
# logs_popcount_seq

Sequential board-population counter. Walks an NROWS×NCOLS bit-board one row at a time over a request/acknowledge read port, sums each row with one shared combinational row popcount, and accumulates the board total. Sits between the board-state storage and the game/win-detect logic, which pulses `start` and consumes `total`/`done`.

## Interface

Parameters:
- `NROWS`, default 5: rows per board; must be ≥1.
- `NCOLS`, default 5: bits per row; must be ≥1.

Derived widths:
- `WA = max(1, $clog2(NROWS))`
- `WR = $clog2(NCOLS+1)`
- `WT = $clog2(NROWS*NCOLS+1)`

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  begin a scan; sampled only in IDLE.
- `busy`  out  1  high while a scan is in progress (state REQ).
- `rd_req`  out  1  row read request.
- `rd_addr`  out  WA  row index requested; stable while `rd_req` is high.
- `rd_ack`  in  1  storage accepts the request; `rd_data` is valid in the same cycle.
- `rd_data`  in  NCOLS  row bits; only sampled when `rd_req && rd_ack`.
- `done`  out  1  one-cycle pulse: `total` was just updated.
- `total`  out  WT  popcount of the last completed scan.
- `all_clear`  out  1  `total == 0`.

## Operation

- States: IDLE, REQ, DONE.
- **IDLE:**
  - `start=1`: clear the accumulator, set the row index to 0, go to REQ.
  - `start=0`: stay in IDLE.
- **REQ:**
  - Drive `rd_req=1` and `rd_addr=row`.
  - On `rd_ack`: `acc <= acc + zext(rowcount(rd_data))`.
    - If `row == NROWS-1`: latch the sum into `total` and go to DONE.
    - Otherwise: `row <= row+1` and stay in REQ.
  - Without `rd_ack`: hold `rd_req`, `rd_addr` and `acc` (stall of any length).
- **DONE:**
  - `done=1` for exactly one cycle.
  - Return to IDLE.
- `start` is ignored in REQ and DONE; it is not queued.
- `rd_ack` is ignored while `rd_req=0`.
- Arithmetic:
  - The row count is WR bits, zero-extended to WT.
  - The accumulator is WT bits; overflow cannot occur by construction.
- `total` and `all_clear` hold the previous result for the whole of the next scan. They change only at the DONE entry edge.
- `rd_addr` is 0 when `rd_req=0`.
- Reset mid-scan: the scan is abandoned, no `done` pulse, `total` is cleared.

## Timing

- Reset values: state IDLE, `busy=0`, `rd_req=0`, `rd_addr=0`, `done=0`, `total=0`, `all_clear=1`, row index 0, accumulator 0.
- Latency with `start` at cycle 0 and `rd_ack` tied high:
  - REQ occupies cycles 1..NROWS.
  - `done` and the new `total` appear in cycle NROWS+1.
  - IDLE in cycle NROWS+2; the earliest next `start` is accepted there.
- Each stall cycle (REQ with `rd_ack=0`) adds exactly one cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `rd_ack`/`rd_data` to any output.

## Configuration

- Macro `LOGS_POPSEQ_ROWMAX_EN`.
- Defined:
  - Adds output `row_max` (WR bits): the largest single-row count seen in the last completed scan.
  - Tracked in a running register cleared on `start`.
  - Copied to `row_max` on the same edge as `total`.
  - Reset value 0.
- Undefined: the port and its registers are absent; all other behaviour is identical.

## Structure

- Package `logs_popseq_pkg`:
  - State enum (IDLE/REQ/DONE).
  - Width helper functions for WA/WR/WT.
- One sub-module: `logs_popcount` with `NBITS=NCOLS`. It provides the combinational row count fed from `rd_data`. It is instantiated exactly once and shared across all rows.

## Test plan

- Reset, then NROWS=5/NCOLS=5, `rd_ack` high, all rows `5'b00000`, `start` at cycle 0.
  - Expect `done` at cycle 6, `total=0`, `all_clear=1`.
- Rows `11111, 10101, 00000, 00001, 11000`, `rd_ack` high.
  - Expect `rd_addr` 0..4 on cycles 1..5.
  - Expect `total=11`, `all_clear=0`, `done` at cycle 6.
  - With `LOGS_POPSEQ_ROWMAX_EN`: `row_max=5`.
- Same data with `rd_ack` low for 3 cycles on row 2.
  - Expect `rd_addr=2` held throughout the stall.
  - Expect `done` at cycle 9, `total=11`.
- After a scan giving `total=11`: start a second scan of all-ones rows and pulse `start` mid-scan.
  - Expect the extra `start` ignored and `total=11` until DONE, then `total=25`.
- Assert `rst_n=0` at cycle 3 of a scan.
  - Expect no `done`, `total=0`, `rd_req=0` on the next cycle.
  - A following `start` completes normally.
- NROWS=1/NCOLS=1, data `1`.
  - Expect `done` at cycle 2, `total=1`.
